// File: rtl/handshaked_serializer.sv
// handshaked_serializer
//
// Downstream stage for the handshaked FIFO. Each accepted DATA_WIDTH word is
// emitted as RATIO = DATA_WIDTH/OUT_WIDTH chunks of OUT_WIDTH bits on a
// valid/ready output. The next word can be accepted in the same cycle that the
// last chunk of the current word transfers, so the output has no bubble
// between words.
//
// Ports
//   clk           clock, all state changes on posedge
//   rst_n         asynchronous active-low reset
//   dataIn_data   input word
//   dataIn_vld    input word valid
//   dataIn_rd     ready for an input word (from cnt and dataOut_rd only)
//   dataOut_data  current chunk
//   dataOut_vld   chunk valid
//   dataOut_rd    sink ready
//   dataOut_last  current chunk is the final chunk of its word
//
// Configuration
//   HANDSHAKED_SERIALIZER_MSB_FIRST_EN
//     undefined: chunks are emitted LSB first.
//     defined:   chunks are emitted MSB first.
//   Handshake, counter and timing are the same in both builds.

module handshaked_serializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OUT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] dataIn_data,
    input  logic                  dataIn_vld,
    output logic                  dataIn_rd,
    output logic [OUT_WIDTH-1:0]  dataOut_data,
    output logic                  dataOut_vld,
    input  logic                  dataOut_rd,
    output logic                  dataOut_last
);

    localparam int unsigned RATIO = DATA_WIDTH / OUT_WIDTH;
    localparam int unsigned CNT_W = $clog2(RATIO + 1);

    localparam logic [CNT_W-1:0] CntFull = CNT_W'(RATIO);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntZero = '0;

    // shift_q holds the not-yet-emitted chunks of the current word.
    // cnt_q counts chunks still to emit.
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic in_xfer;
    logic out_xfer;

    always_comb begin
        dataOut_vld  = (cnt_q != CntZero);
        dataOut_last = (cnt_q == CntOne);
        // Ready when empty, or when the last chunk leaves this cycle.
        dataIn_rd    = (cnt_q == CntZero) | ((cnt_q == CntOne) & dataOut_rd);
`ifdef HANDSHAKED_SERIALIZER_MSB_FIRST_EN
        dataOut_data = shift_q[DATA_WIDTH-1 -: OUT_WIDTH];
`else
        dataOut_data = shift_q[OUT_WIDTH-1:0];
`endif
    end

    assign in_xfer  = dataIn_vld & dataIn_rd;
    assign out_xfer = dataOut_vld & dataOut_rd;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        // Loading wins over a simultaneous last-chunk transfer (back-to-back).
        if (in_xfer) begin
            shift_d = dataIn_data;
            cnt_d   = CntFull;
        end else if (out_xfer) begin
`ifdef HANDSHAKED_SERIALIZER_MSB_FIRST_EN
            shift_d = shift_q << OUT_WIDTH;
`else
            shift_d = shift_q >> OUT_WIDTH;
`endif
            cnt_d   = cnt_q - CntOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_handshaked_serializer.sv
// Self-checking bench for handshaked_serializer (DATA_WIDTH=8, OUT_WIDTH=2).
// Each vector is one clock cycle: inputs are driven after the falling edge and
// outputs compared 1 time unit later, before the next rising edge.

module tb_handshaked_serializer;

    logic       clk;
    logic       rst_n;
    logic [7:0] dataIn_data;
    logic       dataIn_vld;
    logic       dataIn_rd;
    logic [1:0] dataOut_data;
    logic       dataOut_vld;
    logic       dataOut_rd;
    logic       dataOut_last;

    logic run;
    int   errors;
    int   checks;

    handshaked_serializer #(
        .DATA_WIDTH(8),
        .OUT_WIDTH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dataIn_data (dataIn_data),
        .dataIn_vld  (dataIn_vld),
        .dataIn_rd   (dataIn_rd),
        .dataOut_data(dataOut_data),
        .dataOut_vld (dataOut_vld),
        .dataOut_rd  (dataOut_rd),
        .dataOut_last(dataOut_last)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (run) clk = ~clk;
    end

    typedef struct {
        logic       rst;    // pulse async reset during this cycle
        logic [7:0] din;
        logic       vld;
        logic       ordy;
        logic [1:0] edata;
        logic       evld;
        logic       elast;
        logic       einrd;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic [7:0] din, input logic vld,
                       input logic ordy, input logic [1:0] edata, input logic evld,
                       input logic elast, input logic einrd);
        vec_t v;
        v.rst   = rst;
        v.din   = din;
        v.vld   = vld;
        v.ordy  = ordy;
        v.edata = edata;
        v.evld  = evld;
        v.elast = elast;
        v.einrd = einrd;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] edata, input logic evld,
                              input logic elast, input logic einrd);
        check({tag, " data"}, {6'd0, dataOut_data}, {6'd0, edata});
        check({tag, " vld"},  {7'd0, dataOut_vld},  {7'd0, evld});
        check({tag, " last"}, {7'd0, dataOut_last}, {7'd0, elast});
        check({tag, " in_rd"}, {7'd0, dataIn_rd},   {7'd0, einrd});
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        run         = 1'b0;
        dataIn_data = 8'h00;
        dataIn_vld  = 1'b0;
        dataOut_rd  = 1'b1;
        rst_n       = 1'b1;

        // Reset with the clock stopped: outputs must settle without an edge.
        #1 rst_n = 1'b0;
        #1;
        check_outs("reset", 2'd0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        #1 run = 1'b1;

`ifdef HANDSHAKED_SERIALIZER_MSB_FIRST_EN
        // 0xB4 = 10_11_01_00 -> 2,3,1,0
        add(0, 8'hB4, 1, 1, 2'd0, 0, 0, 1);
        add(0, 8'h00, 0, 1, 2'd2, 1, 0, 0);
        add(0, 8'h00, 0, 1, 2'd3, 1, 0, 0);
        add(0, 8'h00, 0, 1, 2'd1, 1, 0, 0);
        add(0, 8'h00, 0, 1, 2'd0, 1, 1, 1);
        add(0, 8'h00, 0, 1, 2'd0, 0, 0, 1);
        // Back-to-back 0xB4 then 0x1E (00_01_11_10 -> 0,1,3,2)
        add(0, 8'hB4, 1, 1, 2'd0, 0, 0, 1);
        add(0, 8'h1E, 1, 1, 2'd2, 1, 0, 0);
        add(0, 8'h1E, 1, 1, 2'd3, 1, 0, 0);
        add(0, 8'h1E, 1, 1, 2'd1, 1, 0, 0);
        add(0, 8'h1E, 1, 1, 2'd0, 1, 1, 1);
        add(0, 8'h00, 0, 1, 2'd0, 1, 0, 0);
        add(0, 8'h00, 0, 1, 2'd1, 1, 0, 0);
        add(0, 8'h00, 0, 1, 2'd3, 1, 0, 0);
        add(0, 8'h00, 0, 1, 2'd2, 1, 1, 1);
        add(0, 8'h00, 0, 1, 2'd0, 0, 0, 1);
`else
        // Single word 0xB4 -> 0,1,3,2
        add(0, 8'hB4, 1, 1, 2'd0, 0, 0, 1);
        add(0, 8'h00, 0, 1, 2'd0, 1, 0, 0);
        add(0, 8'h00, 0, 1, 2'd1, 1, 0, 0);
        add(0, 8'h00, 0, 1, 2'd3, 1, 0, 0);
        add(0, 8'h00, 0, 1, 2'd2, 1, 1, 1);
        add(0, 8'h00, 0, 1, 2'd0, 0, 0, 1);
        // Back-to-back 0xB4, 0x1E held valid until accepted
        add(0, 8'hB4, 1, 1, 2'd0, 0, 0, 1);
        add(0, 8'h1E, 1, 1, 2'd0, 1, 0, 0);
        add(0, 8'h1E, 1, 1, 2'd1, 1, 0, 0);
        add(0, 8'h1E, 1, 1, 2'd3, 1, 0, 0);
        add(0, 8'h1E, 1, 1, 2'd2, 1, 1, 1);
        add(0, 8'h00, 0, 1, 2'd2, 1, 0, 0);
        add(0, 8'h00, 0, 1, 2'd3, 1, 0, 0);
        add(0, 8'h00, 0, 1, 2'd1, 1, 0, 0);
        add(0, 8'h00, 0, 1, 2'd0, 1, 1, 1);
        add(0, 8'h00, 0, 1, 2'd0, 0, 0, 1);
        // Backpressure after chunk 1 appears; a busy-time word is refused
        add(0, 8'hB4, 1, 1, 2'd0, 0, 0, 1);
        add(0, 8'h00, 0, 1, 2'd0, 1, 0, 0);
        add(0, 8'hFF, 1, 0, 2'd1, 1, 0, 0);
        add(0, 8'hFF, 1, 0, 2'd1, 1, 0, 0);
        add(0, 8'hFF, 1, 0, 2'd1, 1, 0, 0);
        add(0, 8'h00, 0, 1, 2'd1, 1, 0, 0);
        add(0, 8'h00, 0, 1, 2'd3, 1, 0, 0);
        add(0, 8'h00, 0, 1, 2'd2, 1, 1, 1);
        add(0, 8'h00, 0, 1, 2'd0, 0, 0, 1);
        // Reset mid-word after chunks 0 and 1 transfer, then 0x1E -> 2,3,1,0
        add(0, 8'hB4, 1, 1, 2'd0, 0, 0, 1);
        add(0, 8'h00, 0, 1, 2'd0, 1, 0, 0);
        add(0, 8'h00, 0, 1, 2'd1, 1, 0, 0);
        add(1, 8'h00, 0, 1, 2'd0, 0, 0, 1);
        add(0, 8'h1E, 1, 1, 2'd0, 0, 0, 1);
        add(0, 8'h00, 0, 1, 2'd2, 1, 0, 0);
        add(0, 8'h00, 0, 1, 2'd3, 1, 0, 0);
        add(0, 8'h00, 0, 1, 2'd1, 1, 0, 0);
        add(0, 8'h00, 0, 1, 2'd0, 1, 1, 1);
        add(0, 8'h00, 0, 1, 2'd0, 0, 0, 1);
`endif

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            dataIn_data = vq[i].din;
            dataIn_vld  = vq[i].vld;
            dataOut_rd  = vq[i].ordy;
            if (vq[i].rst) rst_n = 1'b0;
            #1;
            check_outs($sformatf("v%0d", i), vq[i].edata, vq[i].evld, vq[i].elast,
                       vq[i].einrd);
            if (vq[i].rst) begin
                #1 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
